// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor
//   Passive VGA timing monitor. Measures the line period, the hsync width and
//   the number of lines per frame, and declares lock once a full clean frame
//   matches the nominal timing. For every frame it reports the line count,
//   the number of active pixels and (optionally) a CRC-16-CCITT over the
//   active pixels. The block is free-running: there is no handshake.
//
//   Optional feature macro: VGA_RX_CRC_EN
//     defined   -> CRC datapath present, crc_out holds the CRC of the last frame
//     undefined -> no CRC logic, crc_out is tied to 16'h0000
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hsync        horizontal sync, active-low, already synchronous to clk
//   vsync        vertical sync, active-low, already synchronous to clk
//   rgb[5:0]     pixel {R1,G1,B1,R0,G0,B0}
//   locked       1 while the timing is locked
//   frame_done   one-cycle pulse after each vsync fall outside SEARCH
//   line_len     period of the last complete line (pixel clocks)
//   frame_lines  line count of the last frame
//   px_count     active pixels seen in the last frame
//   crc_out      CRC of the active pixels of the last frame
//   err_cnt      number of lock losses, saturating at 255

module vga_rx_monitor #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned V_ACT   = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [5:0]  rgb,
    output logic        locked,
    output logic        frame_done,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic [18:0] px_count,
    output logic [15:0] crc_out,
    output logic [7:0]  err_cnt
);

    localparam logic [9:0]  H_TOTAL_W = 10'(H_TOTAL);
    localparam logic [9:0]  H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
    localparam logic [10:0] H_ACT_LO  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_HI  = 11'(H_SYNC + H_BP + H_ACT);
    localparam logic [10:0] V_ACT_LO  = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_HI  = 11'(V_SYNC + V_BP + V_ACT);
    localparam logic [9:0]  SAT10     = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state, next_state;

    logic        hs_q, vs_q;
    logic        hs_fall, hs_rise, vs_fall;
    logic [9:0]  idx, cur_idx, idx_next;
    logic        hs_seen;
    logic [9:0]  hs_width;
    logic [9:0]  line_cnt, cur_line, frame_cnt, new_len;
    logic [18:0] px_run;
    logic        active;
    logic        period_bad, frame_ok, frame_clean, frame_good;
    logic        lock_drop, frame_evt;

    // Single sample register; edges compare it against the live input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
        end
    end

    assign hs_fall = hs_q & ~hsync;
    assign hs_rise = ~hs_q & hsync;
    assign vs_fall = vs_q & ~vsync;

    always_comb begin
        cur_idx  = hs_fall ? '0 : idx;
        idx_next = (cur_idx == SAT10) ? cur_idx : cur_idx + 10'd1;

        // vsync fall wins over a coincident hsync fall.
        if (vs_fall)
            cur_line = '0;
        else if (hs_fall)
            cur_line = (line_cnt == SAT10) ? line_cnt : line_cnt + 10'd1;
        else
            cur_line = line_cnt;

        // Lines in the frame just ending, counting the line closed this cycle.
        if (hs_fall)
            frame_cnt = (line_cnt == SAT10) ? line_cnt : line_cnt + 10'd1;
        else
            frame_cnt = line_cnt;

        new_len = (hs_fall && hs_seen) ? idx : line_len;

        active = ({1'b0, cur_idx} >= H_ACT_LO) && ({1'b0, cur_idx} < H_ACT_HI) &&
                 ({1'b0, cur_line} >= V_ACT_LO) && ({1'b0, cur_line} < V_ACT_HI);

        // Lock is only granted after a whole frame in which every line period
        // was nominal; frame_ok tracks that since the last vsync fall.
        period_bad  = hs_fall && hs_seen && (idx != H_TOTAL_W);
        frame_clean = frame_ok && !period_bad;
        frame_good  = frame_clean && (frame_cnt == V_TOTAL_W) &&
                      (new_len == H_TOTAL_W) && (hs_width == H_SYNC_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            hs_seen  <= 1'b0;
            hs_width <= '0;
            line_len <= '0;
            line_cnt <= '0;
            px_run   <= '0;
            frame_ok <= 1'b0;
        end else begin
            idx      <= idx_next;
            line_cnt <= cur_line;
            frame_ok <= vs_fall | frame_clean;
            if (hs_fall) begin
                hs_seen <= 1'b1;
                if (hs_seen)
                    line_len <= idx;
            end
            if (hs_rise)
                hs_width <= cur_idx;
            if (vs_fall)
                px_run <= '0;
            else if (active)
                px_run <= px_run + 19'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SEARCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        lock_drop  = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall)
                    next_state = MEASURE;
            end
            MEASURE: begin
                if (vs_fall && frame_good)
                    next_state = LOCKED;
            end
            LOCKED: begin
                if (period_bad || (vs_fall && (frame_cnt != V_TOTAL_W))) begin
                    next_state = MEASURE;
                    lock_drop  = 1'b1;
                end
            end
            default: next_state = SEARCH;
        endcase
        frame_evt = vs_fall && (state != SEARCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            frame_lines <= '0;
            px_count    <= '0;
            err_cnt     <= '0;
        end else begin
            locked     <= (next_state == LOCKED);
            frame_done <= frame_evt;
            if (frame_evt) begin
                frame_lines <= frame_cnt;
                px_count    <= px_run;
            end
            if (lock_drop && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_run;

    // CRC-16-CCITT (0x1021, non-reflected), rgb[5] shifted in first.
    function automatic logic [15:0] crc6_step(input logic [15:0] crc_in,
                                              input logic [5:0]  d);
        logic [15:0] c;
        logic [5:0]  dd;
        c  = crc_in;
        dd = d;
        for (int unsigned i = 0; i < 6; i++) begin
            if (c[15] ^ dd[5])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
            dd = {dd[4:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_run <= '1;
            crc_out <= '0;
        end else begin
            if (frame_evt)
                crc_out <= crc_run;
            if (vs_fall)
                crc_run <= '1;
            else if (active)
                crc_run <= crc6_step(crc_run, rgb);
        end
    end
`else
    logic unused_rgb;
    assign unused_rgb = ^rgb;
    assign crc_out    = '0;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor
//   Directed bench for vga_rx_monitor using a reduced 40x20 timing
//   (sync 4, back porch 4, 24 active pixels; vsync 2, back porch 3, 12 lines).
//   Each table row drives one frame starting with a coincident hsync/vsync
//   fall and lists the outputs expected at the end of that frame. A few
//   hand-written sequences cover reset behaviour.

module tb_vga_rx_monitor;

    localparam int HT = 40, HS = 4, HB = 4, HA = 24;
    localparam int VT = 20, VS = 2, VB = 3, VA = 12;
    localparam int HA0 = HS + HB, HA1 = HS + HB + HA;
    localparam int VA0 = VS + VB, VA1 = VS + VB + VA;
    localparam int FLIP_PX = 15;

    logic        clk = 1'b0;
    logic        rst_n, hsync, vsync;
    logic [5:0]  rgb;
    logic        locked, frame_done;
    logic [9:0]  line_len, frame_lines;
    logic [18:0] px_count;
    logic [15:0] crc_out;
    logic [7:0]  err_cnt;

    vga_rx_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .locked(locked), .frame_done(frame_done), .line_len(line_len),
        .frame_lines(frame_lines), .px_count(px_count), .crc_out(crc_out),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         bad_line;   // -1: none
        int         bad_len;
        logic [5:0] pix;
        int         flip_line;  // -1: none
        bit         exp_done;
        bit         exp_locked;
        int         exp_lines;
        int         exp_px;
        int         exp_err;
        int         exp_len_bad;
    } vec_t;

    vec_t vecs[12];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt;
    logic        done_p0, done_p1, lock_pre, lock_post;
    logic [9:0]  len_post;
    logic [15:0] frame_crc_m, prev_crc, exp_crc;

    function automatic vec_t mk(int bl, int blen, logic [5:0] px, int fl,
                                bit d, bit lk, int ln, int pc, int er, int lb);
        vec_t v;
        v.bad_line = bl; v.bad_len = blen; v.pix = px; v.flip_line = fl;
        v.exp_done = d; v.exp_locked = lk; v.exp_lines = ln; v.exp_px = pc;
        v.exp_err = er; v.exp_len_bad = lb;
        return v;
    endfunction

    function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [5:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 5; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Drives n_lines lines of a frame; line 0 starts with hsync and vsync
    // falling together. Records observations used by the caller.
    task automatic run_frame(input vec_t v, input int n_lines);
        int         len;
        logic [5:0] px;
        frame_crc_m = 16'hFFFF;
        done_cnt    = 0;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == v.bad_line) ? v.bad_len : HT;
            for (int p = 0; p < len; p++) begin
                @(posedge clk); #1;
                hsync = (p < HS) ? 1'b0 : 1'b1;
                vsync = (l < VS) ? 1'b0 : 1'b1;
                px    = (l == v.flip_line && p == FLIP_PX) ? 6'h00 : v.pix;
                rgb   = px;
                if (l >= VA0 && l < VA1 && p >= HA0 && p < HA1)
                    frame_crc_m = crc_px(frame_crc_m, px);
                @(negedge clk);
                done_cnt += int'(frame_done);
                if (l == 0 && p == 0) done_p0 = frame_done;
                if (l == 0 && p == 1) done_p1 = frame_done;
                if (l == v.bad_line + 1 && p == 0) lock_pre = locked;
                if (l == v.bad_line + 1 && p == 1) begin
                    lock_post = locked;
                    len_post  = line_len;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0;
        prev_crc = 16'hFFFF;

        //            bad  len   pix    flip done lk  lines px   err lenbad
        vecs[0]  = mk(-1,  0,    6'h00, -1,  0,   0,  0,    0,   0,  0);
        vecs[1]  = mk(-1,  0,    6'h00, -1,  1,   1,  VT,   288, 0,  0);
        vecs[2]  = mk(-1,  0,    6'h00, -1,  1,   1,  VT,   288, 0,  0);
        vecs[3]  = mk(10,  41,   6'h00, -1,  1,   0,  VT,   288, 1,  41);
        vecs[4]  = mk(-1,  0,    6'h00, -1,  1,   0,  VT,   288, 1,  0);
        vecs[5]  = mk(-1,  0,    6'h00, -1,  1,   1,  VT,   288, 1,  0);
        vecs[6]  = mk(-1,  0,    6'h3F, -1,  1,   1,  VT,   288, 1,  0);
        vecs[7]  = mk(-1,  0,    6'h3F, -1,  1,   1,  VT,   288, 1,  0);
        vecs[8]  = mk(-1,  0,    6'h3F, 10,  1,   1,  VT,   288, 1,  0);
        vecs[9]  = mk(-1,  0,    6'h3F, -1,  1,   1,  VT,   288, 1,  0);
        vecs[10] = mk(3,   1100, 6'h3F, -1,  1,   0,  VT,   288, 2,  1023);
        vecs[11] = mk(-1,  0,    6'h00, -1,  1,   0,  VT,   288, 2,  0);

        // Reset state, sampled while rst_n is still low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_line_len", line_len, 0);
        chk("rst_frame_lines", frame_lines, 0);
        chk("rst_px_count", px_count, 0);
        chk("rst_crc_out", crc_out, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            run_frame(vecs[i], VT);
`ifdef VGA_RX_CRC_EN
            exp_crc = vecs[i].exp_done ? prev_crc : 16'h0000;
`else
            exp_crc = 16'h0000;
`endif
            prev_crc = frame_crc_m;
            chk($sformatf("v%0d_done_cnt", i), done_cnt, vecs[i].exp_done);
            chk($sformatf("v%0d_done_p0", i), done_p0, 0);
            chk($sformatf("v%0d_done_p1", i), done_p1, vecs[i].exp_done);
            chk($sformatf("v%0d_locked", i), locked, vecs[i].exp_locked);
            chk($sformatf("v%0d_frame_lines", i), frame_lines, vecs[i].exp_lines);
            chk($sformatf("v%0d_px_count", i), px_count, vecs[i].exp_px);
            chk($sformatf("v%0d_line_len", i), line_len, HT);
            chk($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
            chk($sformatf("v%0d_crc_out", i), crc_out, exp_crc);
            if (vecs[i].bad_line >= 0) begin
                chk($sformatf("v%0d_lock_at_fall", i), lock_pre, 1);
                chk($sformatf("v%0d_lock_after_fall", i), lock_post, 0);
                chk($sformatf("v%0d_len_after_bad", i), len_post, vecs[i].exp_len_bad);
            end
        end

        // Reset in the middle of a locked frame.
        run_frame(mk(-1, 0, 6'h00, -1, 0, 0, 0, 0, 0, 0), 10);
        chk("pre_reset_locked", locked, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_frame_done", frame_done, 0);
        chk("async_rst_line_len", line_len, 0);
        chk("async_rst_frame_lines", frame_lines, 0);
        chk("async_rst_px_count", px_count, 0);
        chk("async_rst_crc_out", crc_out, 0);
        chk("async_rst_err_cnt", err_cnt, 0);
        hsync = 1'b1; vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_frame(mk(-1, 0, 6'h00, -1, 0, 0, 0, 0, 0, 0), VT);
        prev_crc = frame_crc_m;
        chk("post_rst_f1_done_cnt", done_cnt, 0);
        chk("post_rst_f1_locked", locked, 0);
        chk("post_rst_f1_px_count", px_count, 0);
        chk("post_rst_f1_frame_lines", frame_lines, 0);

        run_frame(mk(-1, 0, 6'h3F, -1, 0, 0, 0, 0, 0, 0), VT);
`ifdef VGA_RX_CRC_EN
        exp_crc = prev_crc;
`else
        exp_crc = 16'h0000;
`endif
        chk("post_rst_f2_done_cnt", done_cnt, 1);
        chk("post_rst_f2_done_p1", done_p1, 1);
        chk("post_rst_f2_locked", locked, 1);
        chk("post_rst_f2_frame_lines", frame_lines, VT);
        chk("post_rst_f2_px_count", px_count, 288);
        chk("post_rst_f2_err_cnt", err_cnt, 0);
        chk("post_rst_f2_crc_out", crc_out, exp_crc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
